// File: rtl/btb_assoc_predictor.sv
// Set-associative branch target buffer with per-way saturating direction counters
// and age-ordered (LRU) replacement. Lookup is combinational; updates land on the next edge.
module btb_assoc_predictor #(
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_if,
  output logic                  hit_if,
  output logic                  jump_if,
  output logic [ADDR_WIDTH-1:0] pc_target_if,
  input  logic [ADDR_WIDTH-1:0] pc_exe,
  input  logic [ADDR_WIDTH-1:0] pc_target_exe,
  input  logic                  jump_exe,
  input  logic                  is_jump_exe,
  input  logic                  flush
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

  logic                  r_valid  [SETS][WAYS];
  logic [TAG_W-1:0]      r_tag    [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] r_target [SETS][WAYS];
  logic [CNT_WIDTH-1:0]  r_cnt    [SETS][WAYS];
  logic [WAY_W-1:0]      r_age    [SETS][WAYS];

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_if_hit;
  logic [WAY_W-1:0] w_if_way;
  logic             w_ex_hit;
  logic [WAY_W-1:0] w_ex_way;
  logic             w_inv_found;
  logic [WAY_W-1:0] w_victim;
  logic [WAY_W-1:0] w_touch_way;
  logic [WAY_W-1:0] w_old_age;
  logic             w_do_update;
  logic             w_unused;

  // Instruction-alignment bits never take part in index or tag.
  assign w_unused = ^{pc_if[1:0], pc_exe[1:0]};

  assign w_if_idx = pc_if[2 +: IDX_W];
  assign w_if_tag = pc_if[ADDR_WIDTH-1 -: TAG_W];
  assign w_ex_idx = pc_exe[2 +: IDX_W];
  assign w_ex_tag = pc_exe[ADDR_WIDTH-1 -: TAG_W];

  always_comb begin
    w_if_hit = 1'b0;
    w_if_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_if_idx][w] && (r_tag[w_if_idx][w] == w_if_tag)) begin
        w_if_hit = 1'b1;
        w_if_way = WAY_W'(w);
      end
    end
  end

  assign hit_if       = w_if_hit;
  assign jump_if      = w_if_hit & r_cnt[w_if_idx][w_if_way][CNT_WIDTH-1];
  assign pc_target_if = w_if_hit ? r_target[w_if_idx][w_if_way] : '0;

  always_comb begin
    w_ex_hit    = 1'b0;
    w_ex_way    = '0;
    w_inv_found = 1'b0;
    w_victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_ex_idx][w] && (r_tag[w_ex_idx][w] == w_ex_tag)) begin
        w_ex_hit = 1'b1;
        w_ex_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_ex_idx][w]) begin
        w_inv_found = 1'b1;
        w_victim    = WAY_W'(w);
      end
    end
    if (!w_inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[w_ex_idx][w] == WAY_W'(WAYS - 1)) begin
          w_victim = WAY_W'(w);
        end
      end
    end
  end

  assign w_touch_way = w_ex_hit ? w_ex_way : w_victim;
  assign w_old_age   = r_age[w_ex_idx][w_touch_way];
  assign w_do_update = is_jump_exe & (w_ex_hit | jump_exe);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w]  <= 1'b0;
          r_tag[s][w]    <= '0;
          r_target[s][w] <= '0;
          r_cnt[s][w]    <= '0;
          r_age[s][w]    <= WAY_W'(w);
        end
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
    end else if (w_do_update) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == w_touch_way) begin
          r_valid[w_ex_idx][w] <= 1'b1;
          r_tag[w_ex_idx][w]   <= w_ex_tag;
          r_age[w_ex_idx][w]   <= '0;
          if (jump_exe) begin
            r_target[w_ex_idx][w] <= pc_target_exe;
          end
          if (w_ex_hit) begin
            if (jump_exe) begin
              if (r_cnt[w_ex_idx][w] != CNT_MAX) begin
                r_cnt[w_ex_idx][w] <= r_cnt[w_ex_idx][w] + CNT_WIDTH'(1);
              end
            end else if (r_cnt[w_ex_idx][w] != '0) begin
              r_cnt[w_ex_idx][w] <= r_cnt[w_ex_idx][w] - CNT_WIDTH'(1);
            end
          end else begin
            r_cnt[w_ex_idx][w] <= CNT_INIT;
          end
        end else if (r_age[w_ex_idx][w] < w_old_age) begin
          r_age[w_ex_idx][w] <= r_age[w_ex_idx][w] + WAY_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc_predictor.sv
// Directed bench for btb_assoc_predictor: the driver queues expected lookup results,
// a negedge monitor pops and compares them against the combinational outputs.
module tb_btb_assoc_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        jump_exe;
  logic        is_jump_exe;
  logic [63:0] pc_if;
  logic [63:0] pc_exe;
  logic [63:0] pc_target_exe;
  logic        hit_if;
  logic        jump_if;
  logic [63:0] pc_target_if;

  btb_assoc_predictor #(
    .SETS(16), .WAYS(2), .ADDR_WIDTH(64), .CNT_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_if(pc_if),
    .hit_if(hit_if),
    .jump_if(jump_if),
    .pc_target_if(pc_target_if),
    .pc_exe(pc_exe),
    .pc_target_exe(pc_target_exe),
    .jump_exe(jump_exe),
    .is_jump_exe(is_jump_exe),
    .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] pc;
    logic        hit;
    logic        jump;
    logic [63:0] tgt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   look_vld = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_look   = 0;

  always @(negedge clk) begin
    if (look_vld) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: lookup presented with no expectation queued, pc=%h", pc_if);
      end else begin
        mon_e = sb.pop_front();
        if (hit_if !== mon_e.hit || jump_if !== mon_e.jump || pc_target_if !== mon_e.tgt) begin
          n_err++;
          $display("FAIL lookup#%0d pc=%h: got hit=%b jump=%b tgt=%h, want hit=%b jump=%b tgt=%h",
                   mon_e.id, mon_e.pc, hit_if, jump_if, pc_target_if, mon_e.hit, mon_e.jump, mon_e.tgt);
        end else begin
          $display("ok   lookup#%0d pc=%h hit=%b jump=%b tgt=%h",
                   mon_e.id, mon_e.pc, hit_if, jump_if, pc_target_if);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    look_vld    = 1'b0;
    is_jump_exe = 1'b0;
    jump_exe    = 1'b0;
    flush       = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic set_look(input logic [63:0] pc, input logic h, input logic j, input logic [63:0] t);
    exp_t e;
    e.id   = n_look;
    e.pc   = pc;
    e.hit  = h;
    e.jump = j;
    e.tgt  = t;
    sb.push_back(e);
    n_look++;
    pc_if    = pc;
    look_vld = 1'b1;
  endtask

  task automatic set_upd(input logic [63:0] pc, input logic [63:0] t, input logic tk);
    is_jump_exe   = 1'b1;
    pc_exe        = pc;
    pc_target_exe = t;
    jump_exe      = tk;
  endtask

  task automatic look(input logic [63:0] pc, input logic h, input logic j, input logic [63:0] t);
    set_look(pc, h, j, t);
    tick();
    clr();
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] t, input logic tk);
    set_upd(pc, t, tk);
    tick();
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    rst           = 1'b1;
    pc_if         = '0;
    pc_exe        = '0;
    pc_target_exe = '0;
    tick();
    tick();
    clr();

    // Post-reset lookups miss
    look(64'h1000, 0, 0, 64'h0);
    look(64'h0000, 0, 0, 64'h0);

    // Allocation; same-cycle lookup sees pre-update state
    set_upd(64'h1000, 64'h2000, 1);
    set_look(64'h1000, 0, 0, 64'h0);
    tick(); clr();
    look(64'h1000, 1, 1, 64'h2000);
    look(64'h1004, 0, 0, 64'h0);
    look(64'h1002, 1, 1, 64'h2000);

    // EXE inputs ignored without is_jump_exe
    pc_exe = 64'h1000; pc_target_exe = 64'hDEAD; jump_exe = 1'b0;
    tick(); tick();
    look(64'h1000, 1, 1, 64'h2000);

    // Counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01
    upd(64'h1000, 64'h9999, 0);
    look(64'h1000, 1, 0, 64'h2000);
    upd(64'h1000, 64'h9999, 0);
    look(64'h1000, 1, 0, 64'h2000);
    upd(64'h1000, 64'h9999, 0);
    upd(64'h1000, 64'h2000, 1);
    look(64'h1000, 1, 0, 64'h2000);
    upd(64'h1000, 64'h2400, 1);
    look(64'h1000, 1, 1, 64'h2400);
    upd(64'h1000, 64'h2400, 1);
    upd(64'h1000, 64'h2400, 1);
    upd(64'h1000, 64'h7777, 0);
    look(64'h1000, 1, 1, 64'h2400);
    upd(64'h1000, 64'h7777, 0);
    look(64'h1000, 1, 0, 64'h2400);

    // Not-taken miss does not allocate
    upd(64'h3000, 64'h4000, 0);
    look(64'h3000, 0, 0, 64'h0);
    look(64'h1000, 1, 0, 64'h2400);

    // Replacement in set 0: 0x1000 in way0, 0x1040 fills way1, hit 0x1000, 0x1080 evicts 0x1040
    upd(64'h1040, 64'h3040, 1);
    look(64'h1040, 1, 1, 64'h3040);
    upd(64'h1000, 64'h2400, 1);
    upd(64'h1080, 64'h3080, 1);
    look(64'h1040, 0, 0, 64'h0);
    look(64'h1000, 1, 1, 64'h2400);
    look(64'h1080, 1, 1, 64'h3080);
    upd(64'h10C0, 64'h30C0, 1);
    look(64'h1000, 0, 0, 64'h0);
    look(64'h10C0, 1, 1, 64'h30C0);
    look(64'h1080, 1, 1, 64'h3080);

    // Flush beats a same-cycle taken update
    flush = 1'b1;
    set_upd(64'h5000, 64'h6000, 1);
    set_look(64'h1080, 1, 1, 64'h3080);
    tick(); clr();
    look(64'h5000, 0, 0, 64'h0);
    look(64'h1000, 0, 0, 64'h0);
    look(64'h1080, 0, 0, 64'h0);
    look(64'h10C0, 0, 0, 64'h0);

    // Post-flush ages restored: fill way0, way1, then way0 is the victim
    upd(64'h1000, 64'h2000, 1);
    upd(64'h1040, 64'h3040, 1);
    upd(64'h1080, 64'h3080, 1);
    look(64'h1000, 0, 0, 64'h0);
    look(64'h1040, 1, 1, 64'h3040);
    look(64'h1080, 1, 1, 64'h3080);

    // Reset beats a same-cycle taken update
    rst = 1'b1;
    set_upd(64'h1000, 64'h2000, 1);
    tick(); clr();
    look(64'h1000, 0, 0, 64'h0);
    look(64'h1040, 0, 0, 64'h0);
    upd(64'h1000, 64'h2000, 1);
    upd(64'h1040, 64'h3040, 1);
    upd(64'h1080, 64'h3080, 1);
    look(64'h1000, 0, 0, 64'h0);
    look(64'h1040, 1, 1, 64'h3040);
    look(64'h1080, 1, 1, 64'h3080);

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d expectations left in queue, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/btb_assoc_predictor.md
BTB_ASSOC_PREDICTOR -- requirements
Module: btb_assoc_predictor

Interface
REQ-001 The block SHALL have parameter SETS, default 16, meaning number of sets; power of two, >=2.
REQ-002 The block SHALL have parameter WAYS, default 2, meaning ways per set; power of two, >=2.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 64, meaning PC and target width.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 2, meaning saturating-counter width; >=1.
REQ-005 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst  input  1  meaning reset; synchronous and active-high.
REQ-007 The block SHALL have port pc_if  input  ADDR_WIDTH  meaning the fetch PC to look up.
REQ-008 The block SHALL have port hit_if  output  1  meaning pc_if matches a valid entry.
REQ-009 The block SHALL have port jump_if  output  1  meaning predict taken.
REQ-010 The block SHALL have port pc_target_if  output  ADDR_WIDTH  meaning the predicted target.
REQ-011 The block SHALL have port pc_exe  input  ADDR_WIDTH  meaning the PC of the resolving branch.
REQ-012 The block SHALL have port pc_target_exe  input  ADDR_WIDTH  meaning the resolved target.
REQ-013 The block SHALL have port jump_exe  input  1  meaning the branch was taken.
REQ-014 The block SHALL have port is_jump_exe  input  1  meaning the EXE update is valid.
REQ-015 The block SHALL have port flush  input  1  meaning invalidate all entries.

Function
REQ-016 The block SHALL form the index from PC[2+log2(SETS)-1:2] and the tag from the PC bits above the index.
REQ-017 The block SHALL store, per way: valid, tag, target, a CNT_WIDTH-bit counter and a log2(WAYS)-bit age.
REQ-018 The block SHALL compute the lookup combinationally: hit_if=1 iff some way in the set is valid with a matching tag.
REQ-019 The block SHALL drive jump_if = hit_if AND MSB of the hit way's counter.
REQ-020 The block SHALL drive pc_target_if = hit way target when hit_if=1, else 0.
REQ-021 The block SHALL hold at most one valid matching way per set at any time.
REQ-022 The block SHALL, on is_jump_exe=1 with a hit at pc_exe, increment the counter if jump_exe=1 and decrement it if jump_exe=0, saturating at 2^CNT_WIDTH-1 and at 0.
REQ-023 The block SHALL, on that hit with jump_exe=1, overwrite the target with pc_target_exe; with jump_exe=0 the target is unchanged.
REQ-024 The block SHALL, on is_jump_exe=1, miss and jump_exe=1, allocate a victim way: the lowest-numbered invalid way, else the way with age WAYS-1.
REQ-025 The block SHALL write an allocated way as valid=1, tag, target=pc_target_exe, counter=2^(CNT_WIDTH-1) (weakly taken).
REQ-026 The block SHALL NOT allocate on is_jump_exe=1 with miss and jump_exe=0; no state changes.
REQ-027 The block SHALL, on each hit-update or allocation, set the touched way's age to 0 and increment by 1 every other way in the set whose age was below the touched way's old age; ages of other sets SHALL be unchanged.
REQ-028 The block SHALL keep the ages within a set a permutation of 0..WAYS-1 at all times.
REQ-029 The block SHALL provide no IF/EXE bypass: a same-cycle lookup of the entry being updated sees pre-update state; the new state is visible the next cycle.
REQ-030 The block SHALL, on flush=1, clear all valid bits and set each way's age to its way number, with counters, tags and targets don't-care; flush SHALL take priority over any same-cycle update.
REQ-031 The block SHALL ignore pc_exe, pc_target_exe and jump_exe when is_jump_exe=0.

Reset
REQ-032 The block SHALL, while rst=1 at a rising edge, clear all valid bits, tags, targets and counters to 0 and set each way's age to its way number.
REQ-033 The block SHALL give rst priority over flush and update.
REQ-034 The block SHALL drive hit_if=0, jump_if=0 and pc_target_if=0 for any pc_if after reset.

Verification
REQ-035 The bench SHALL cover: after reset, pc_if=0x1000 -> hit_if=0, jump_if=0, pc_target_if=0.
REQ-036 The bench SHALL cover: taken update pc_exe=0x1000, target 0x2000 -> next cycle pc_if=0x1000 gives hit_if=1, jump_if=1, target 0x2000, counter 2'b10; then three not-taken updates -> counter 01, 00, 00, and jump_if=0 after the first.
REQ-037 The bench SHALL cover: not-taken update at miss pc_exe=0x3000 -> pc_if=0x3000 gives hit_if=0.
REQ-038 The bench SHALL cover: taken allocations of 0x1000, then 0x1040 (same set 0); then a hit-update on 0x1000; then allocation of 0x1080 -> 0x1040 is evicted (hit_if=0), while 0x1000 and 0x1080 give hit_if=1.
REQ-039 The bench SHALL cover: flush=1 in the same cycle as a taken update of 0x5000 -> next cycle all lookups, including 0x1000 and 0x5000, give hit_if=0.
REQ-040 The bench SHALL cover: rst=1 in the same cycle as is_jump_exe=1 with jump_exe=1 at 0x1000 -> next cycle hit_if=0 and all ages equal their way numbers.
